poly_sched: RTL and testbench
=============================

POLY_SCHED -- requirements
Module: poly_sched

Interface
REQ-001 clk  input  1  rising-edge system clock.
REQ-002 resetn  input  1  synchronous, active-low reset.
REQ-003 req_valid  input  2  per-requester job request; bit i = requester i.
REQ-004 req_ready  output  2  per-requester accept; a job transfers when req_valid[i] & req_ready[i].
REQ-005 req0_data  input  32  requester-0 operands {a[31:24], b[23:16], c[15:8], x[7:0]}.
REQ-006 req1_data  input  32  requester-1 operands, same packing as req0_data.
REQ-007 res_valid  output  1  result available.
REQ-008 res_ready  input  1  result consumer accept; result transfers when res_valid & res_ready.
REQ-009 res_id  output  1  index of the requester that owns res_data.
REQ-010 res_data  output  8  a*x*x + b*x + c, modulo 256.
REQ-011 dp_data_in  output  8  operand byte driven to the shared datapath.
REQ-012 dp_ld_a, dp_ld_b, dp_ld_c, dp_ld_x, dp_ld_r, dp_ld_alu_out  output  1 each  datapath register load enables.
REQ-013 dp_alu_select_a, dp_alu_select_b  output  2 each  ALU operand select (0=A, 1=B, 2=C, 3=X).
REQ-014 dp_alu_op  output  1  0=add, 1=multiply.
REQ-015 dp_result  input  8  datapath result register.
REQ-016 job_count  output  16  completed-job counter (see Configuration).

Function
REQ-017 FSM states SHALL be IDLE, LD_A, LD_B, LD_C, LD_X, C0, C1, C2, C3, C4, DONE.
REQ-018 IDLE: req_ready SHALL be one-hot to the arbitration winner among valid requesters, zero if none; on handshake, operands, winner id latched, next state LD_A.
REQ-019 Arbitration SHALL be round-robin: when both request, winner = priority pointer; after each grant the pointer SHALL point to the other requester; a lone requester always wins.
REQ-020 req_ready SHALL be 0 in every state other than IDLE.
REQ-021 LD_A/LD_B/LD_C/LD_X SHALL each last one cycle, drive dp_data_in = latched a/b/c/x, assert only the matching dp_ld_*, dp_ld_alu_out=0.
REQ-022 C0, C1: A<-A*X (ld_a, ld_alu_out, sel_a=0, sel_b=3, op=1); C2: B<-B*X (ld_b, ld_alu_out, sel_a=1, sel_b=3, op=1); C3: A<-A+B (ld_a, ld_alu_out, sel_a=0, sel_b=1, op=0); C4: R<-A+C (ld_r, sel_a=0, sel_b=2, op=0).
REQ-023 All dp_* outputs not listed for a state SHALL be 0.
REQ-024 DONE: res_valid=1, res_data=dp_result, res_id=latched id; stays until res_ready=1, then IDLE next cycle.
REQ-025 Latency: res_valid SHALL rise exactly 10 cycles after the request handshake edge.
REQ-026 res_data and res_id SHALL be stable while res_valid=1 and res_ready=0.
REQ-027 Arithmetic SHALL be 8-bit, wrap modulo 256, no overflow flag.
REQ-028 Request changes after handshake SHALL not affect the running job.

Reset
REQ-029 On resetn=0 at a clock edge: state IDLE, pointer = requester 0, res_valid=0, res_id=0, latched operands 0, job_count=0, all dp_* = 0.
REQ-030 Reset mid-job SHALL abandon the job with no result delivered.

Configuration
REQ-031 With POLY_SCHED_JOB_CNT_EN defined, job_count SHALL increment on each result handshake, saturating at 0xFFFF.
REQ-032 Without POLY_SCHED_JOB_CNT_EN, job_count SHALL be constant 0 and no counter logic built.

Structure
REQ-033 Package poly_sched_pkg SHALL hold the state enum, ALU select codes, ALU op codes, operand byte offsets.
REQ-034 Two-way round-robin arbitration SHALL be sub-module rr_arbiter2.

Verification
REQ-035 req0 {a=2,b=3,c=4,x=5}, res_ready=1 -> res_data=0x45, res_id=0, res_valid 10 cycles after accept.
REQ-036 req1 {a=3,b=0,c=0,x=10} -> res_data=0x2C (300 mod 256), res_id=1.
REQ-037 Both valid after reset, req1 {1,1,1,1} -> req0 served first, then req1 res_data=0x03 res_id=1.
REQ-038 res_ready low 5 cycles in DONE -> res_valid held, res_data stable, req_ready=00.
REQ-039 resetn low during C2 -> next cycle res_valid=0, state IDLE, following req1-only job granted normally.
REQ-040 Macro defined, 3 completed jobs -> job_count=3; undefined -> job_count=0.

Source files
------------

// File: rtl/poly_sched_pkg.sv
// Shared types and constants for the poly_sched job scheduler.
package poly_sched_pkg;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned REQ_W  = 32;
    localparam int unsigned SEL_W  = 2;
    localparam int unsigned CNT_W  = 16;

    // Byte offsets of the operands inside a request word
    localparam int unsigned OFF_A = 24;
    localparam int unsigned OFF_B = 16;
    localparam int unsigned OFF_C = 8;
    localparam int unsigned OFF_X = 0;

    typedef enum logic [3:0] {
        IDLE, LD_A, LD_B, LD_C, LD_X, C0, C1, C2, C3, C4, DONE
    } state_t;

    typedef enum logic [SEL_W-1:0] {
        SEL_A = 2'd0,
        SEL_B = 2'd1,
        SEL_C = 2'd2,
        SEL_X = 2'd3
    } alu_sel_t;

    typedef enum logic {
        ALU_ADD = 1'b0,
        ALU_MUL = 1'b1
    } alu_op_t;

    typedef struct packed {
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
        logic [DATA_W-1:0] c;
        logic [DATA_W-1:0] x;
    } operands_t;

    function automatic operands_t unpack_ops(input logic [REQ_W-1:0] d);
        operands_t o;
        o.a = d[OFF_A +: DATA_W];
        o.b = d[OFF_B +: DATA_W];
        o.c = d[OFF_C +: DATA_W];
        o.x = d[OFF_X +: DATA_W];
        return o;
    endfunction

endpackage

// File: rtl/poly_sched_rr_arbiter2.sv
// Two-way round-robin arbiter; pointer moves to the other requester after each grant.
module rr_arbiter2 (
    input  logic       clk,
    input  logic       resetn,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] grant_c,
    output logic       grant_id_c
);

    logic ptr;

    always_comb begin
        grant_id_c = 1'b0;
        if (req == 2'b11) begin
            grant_id_c = ptr;
        end else if (req[1]) begin
            grant_id_c = 1'b1;
        end
        grant_c = 2'b00;
        if (req != 2'b00) begin
            grant_c = grant_id_c ? 2'b10 : 2'b01;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            ptr <= 1'b0;
        end else if (advance && (req != 2'b00)) begin
            ptr <= ~grant_id_c;
        end
    end

endmodule

// File: rtl/poly_sched.sv
// Two-requester scheduler sequencing a shared datapath to compute a*x*x + b*x + c.
// Optional completed-job counter: define POLY_SCHED_JOB_CNT_EN.
module poly_sched
    import poly_sched_pkg::*;
(
    input  logic              clk,
    input  logic              resetn,
    input  logic [1:0]        req_valid,
    output logic [1:0]        req_ready,
    input  logic [REQ_W-1:0]  req0_data,
    input  logic [REQ_W-1:0]  req1_data,
    output logic              res_valid,
    input  logic              res_ready,
    output logic              res_id,
    output logic [DATA_W-1:0] res_data,
    output logic [DATA_W-1:0] dp_data_in,
    output logic              dp_ld_a,
    output logic              dp_ld_b,
    output logic              dp_ld_c,
    output logic              dp_ld_x,
    output logic              dp_ld_r,
    output logic              dp_ld_alu_out,
    output logic [SEL_W-1:0]  dp_alu_select_a,
    output logic [SEL_W-1:0]  dp_alu_select_b,
    output logic              dp_alu_op,
    input  logic [DATA_W-1:0] dp_result,
    output logic [CNT_W-1:0]  job_count
);

    state_t            state, next_state;
    operands_t         ops_q, win_ops, cur_ops;
    logic              id_q, win_id, idle, req_fire, res_fire;
    logic [1:0]        grant;
    logic [DATA_W-1:0] data_in_nxt;
    logic              ld_a_nxt, ld_b_nxt, ld_c_nxt, ld_x_nxt, ld_r_nxt, ld_alu_nxt;
    alu_sel_t          sel_a_nxt, sel_b_nxt;
    alu_op_t           op_nxt;

    assign idle      = (state == IDLE);
    assign req_ready = idle ? grant : 2'b00;
    assign req_fire  = |(req_valid & req_ready);
    assign res_fire  = res_valid & res_ready;
    assign win_ops   = unpack_ops(win_id ? req1_data : req0_data);
    // Operands arrive in the same cycle LD_A is entered, so bypass the latch then
    assign cur_ops   = req_fire ? win_ops : ops_q;

    rr_arbiter2 u_arb (
        .clk        (clk),
        .resetn     (resetn),
        .req        (req_valid),
        .advance    (idle),
        .grant_c    (grant),
        .grant_id_c (win_id)
    );

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (req_fire) next_state = LD_A;
            LD_A:    next_state = LD_B;
            LD_B:    next_state = LD_C;
            LD_C:    next_state = LD_X;
            LD_X:    next_state = C0;
            C0:      next_state = C1;
            C1:      next_state = C2;
            C2:      next_state = C3;
            C3:      next_state = C4;
            C4:      next_state = DONE;
            DONE:    if (res_fire) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Datapath controls decoded from the next state so they are registered yet aligned with it
    always_comb begin
        data_in_nxt = '0;
        ld_a_nxt    = 1'b0;
        ld_b_nxt    = 1'b0;
        ld_c_nxt    = 1'b0;
        ld_x_nxt    = 1'b0;
        ld_r_nxt    = 1'b0;
        ld_alu_nxt  = 1'b0;
        sel_a_nxt   = SEL_A;
        sel_b_nxt   = SEL_A;
        op_nxt      = ALU_ADD;
        case (next_state)
            LD_A: begin data_in_nxt = cur_ops.a; ld_a_nxt = 1'b1; end
            LD_B: begin data_in_nxt = cur_ops.b; ld_b_nxt = 1'b1; end
            LD_C: begin data_in_nxt = cur_ops.c; ld_c_nxt = 1'b1; end
            LD_X: begin data_in_nxt = cur_ops.x; ld_x_nxt = 1'b1; end
            C0, C1: begin
                ld_a_nxt = 1'b1; ld_alu_nxt = 1'b1;
                sel_a_nxt = SEL_A; sel_b_nxt = SEL_X; op_nxt = ALU_MUL;
            end
            C2: begin
                ld_b_nxt = 1'b1; ld_alu_nxt = 1'b1;
                sel_a_nxt = SEL_B; sel_b_nxt = SEL_X; op_nxt = ALU_MUL;
            end
            C3: begin
                ld_a_nxt = 1'b1; ld_alu_nxt = 1'b1;
                sel_a_nxt = SEL_A; sel_b_nxt = SEL_B; op_nxt = ALU_ADD;
            end
            C4: begin
                ld_r_nxt = 1'b1;
                sel_a_nxt = SEL_A; sel_b_nxt = SEL_C; op_nxt = ALU_ADD;
            end
            default: ;
        endcase
    end

    // Job context, datapath controls and result holding register
    always_ff @(posedge clk) begin
        if (!resetn) begin
            ops_q           <= '0;
            id_q            <= 1'b0;
            dp_data_in      <= '0;
            dp_ld_a         <= 1'b0;
            dp_ld_b         <= 1'b0;
            dp_ld_c         <= 1'b0;
            dp_ld_x         <= 1'b0;
            dp_ld_r         <= 1'b0;
            dp_ld_alu_out   <= 1'b0;
            dp_alu_select_a <= '0;
            dp_alu_select_b <= '0;
            dp_alu_op       <= 1'b0;
            res_valid       <= 1'b0;
            res_data        <= '0;
            res_id          <= 1'b0;
        end else begin
            if (req_fire) begin
                ops_q <= win_ops;
                id_q  <= win_id;
            end
            dp_data_in      <= data_in_nxt;
            dp_ld_a         <= ld_a_nxt;
            dp_ld_b         <= ld_b_nxt;
            dp_ld_c         <= ld_c_nxt;
            dp_ld_x         <= ld_x_nxt;
            dp_ld_r         <= ld_r_nxt;
            dp_ld_alu_out   <= ld_alu_nxt;
            dp_alu_select_a <= sel_a_nxt;
            dp_alu_select_b <= sel_b_nxt;
            dp_alu_op       <= op_nxt;
            res_valid       <= (state == DONE) && !res_fire;
            // R settles on entry to DONE; capture once and hold until accepted
            if ((state == DONE) && !res_valid) begin
                res_data <= dp_result;
                res_id   <= id_q;
            end
        end
    end

`ifdef POLY_SCHED_JOB_CNT_EN
    always_ff @(posedge clk) begin
        if (!resetn) begin
            job_count <= '0;
        end else if (res_fire && (job_count != {CNT_W{1'b1}})) begin
            job_count <= job_count + CNT_W'(1);
        end
    end
`else
    assign job_count = '0;
`endif

endmodule

// File: tb/tb_poly_sched.sv
// Scoreboard bench for poly_sched: behavioural datapath, randomized jobs, polynomial reference.
module tb_poly_sched;

    logic        clk = 1'b0;
    logic        resetn;
    logic [1:0]  req_valid, req_ready;
    logic [31:0] req0_data, req1_data;
    logic        res_valid, res_ready, res_id;
    logic [7:0]  res_data, dp_data_in, dp_result;
    logic        dp_ld_a, dp_ld_b, dp_ld_c, dp_ld_x, dp_ld_r, dp_ld_alu_out;
    logic [1:0]  dp_alu_select_a, dp_alu_select_b;
    logic        dp_alu_op;
    logic [15:0] job_count;

`ifdef POLY_SCHED_JOB_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    always #5 clk = ~clk;

    poly_sched dut (
        .clk             (clk),
        .resetn          (resetn),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req0_data       (req0_data),
        .req1_data       (req1_data),
        .res_valid       (res_valid),
        .res_ready       (res_ready),
        .res_id          (res_id),
        .res_data        (res_data),
        .dp_data_in      (dp_data_in),
        .dp_ld_a         (dp_ld_a),
        .dp_ld_b         (dp_ld_b),
        .dp_ld_c         (dp_ld_c),
        .dp_ld_x         (dp_ld_x),
        .dp_ld_r         (dp_ld_r),
        .dp_ld_alu_out   (dp_ld_alu_out),
        .dp_alu_select_a (dp_alu_select_a),
        .dp_alu_select_b (dp_alu_select_b),
        .dp_alu_op       (dp_alu_op),
        .dp_result       (dp_result),
        .job_count       (job_count)
    );

    // Shared datapath that the scheduler drives
    logic [7:0] ra, rb, rc, rx, rr, opa, opb, alu_y;

    function automatic logic [7:0] pick(input logic [1:0] s, input logic [7:0] a, b, c, x);
        case (s)
            2'd0:    return a;
            2'd1:    return b;
            2'd2:    return c;
            default: return x;
        endcase
    endfunction

    always_comb begin
        opa   = pick(dp_alu_select_a, ra, rb, rc, rx);
        opb   = pick(dp_alu_select_b, ra, rb, rc, rx);
        alu_y = dp_alu_op ? 8'(opa * opb) : 8'(opa + opb);
    end

    always @(posedge clk) begin
        if (!resetn) begin
            ra <= '0; rb <= '0; rc <= '0; rx <= '0; rr <= '0;
        end else begin
            if (dp_ld_a) ra <= dp_ld_alu_out ? alu_y : dp_data_in;
            if (dp_ld_b) rb <= dp_ld_alu_out ? alu_y : dp_data_in;
            if (dp_ld_c) rc <= dp_data_in;
            if (dp_ld_x) rx <= dp_data_in;
            if (dp_ld_r) rr <= alu_y;
        end
    end
    assign dp_result = rr;

    // Reference model and scoreboard state
    typedef struct packed {
        logic       id;
        logic [7:0] data;
        int         acc;
    } exp_t;

    exp_t       sb[$];
    int         total = 0;
    int         bad = 0;
    int         cyc = 0;
    int         hs_done = 0;
    int         bp_mode = 0;
    logic       ptr_m = 1'b0;
    logic       seen = 1'b0;
    logic [1:0] eg;
    logic       gid;

    function automatic logic [7:0] poly(input logic [31:0] d);
        int a, b, c, x;
        a = int'(d[31:24]); b = int'(d[23:16]); c = int'(d[15:8]); x = int'(d[7:0]);
        return 8'((a * x * x + b * x + c) % 256);
    endfunction

    function automatic logic [15:0] exp_cnt(input int n);
        if (!CNT_EN) return 16'd0;
        return (n >= 65535) ? 16'hFFFF : 16'(n);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: records accepted jobs, checks grants and every presented result
    always @(negedge clk) begin
        if (!resetn) begin
            sb.delete();
            ptr_m   = 1'b0;
            seen    = 1'b0;
            hs_done = 0;
        end else begin
            if (req_ready != 2'b00) begin
                eg = (req_valid == 2'b11) ? (ptr_m ? 2'b10 : 2'b01) : req_valid;
                chk("grant", 32'(req_ready), 32'(eg));
            end
            if ((req_valid & req_ready) != 2'b00) begin
                gid = req_ready[1];
                sb.push_back('{id: gid, data: poly(gid ? req1_data : req0_data), acc: cyc});
                ptr_m = ~gid;
            end
            if (res_valid) begin
                chk("ready_while_result", 32'(req_ready), 32'd0);
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_result actual=%0h required=none", res_data);
                end else begin
                    if (!seen) begin
                        chk("latency", 32'(cyc), 32'(sb[0].acc + 11));
                        seen = 1'b1;
                    end
                    chk("res_data", 32'(res_data), 32'(sb[0].data));
                    chk("res_id", 32'(res_id), 32'(sb[0].id));
                    if (res_ready) begin
                        void'(sb.pop_front());
                        seen = 1'b0;
                        hs_done++;
                    end
                end
            end
        end
    end

    // Result back-pressure: 0 always ready, 1 never ready, otherwise random
    initial begin
        res_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (bp_mode)
                0:       res_ready = 1'b1;
                1:       res_ready = 1'b0;
                default: res_ready = ($urandom_range(0, 3) != 0);
            endcase
        end
    end

    task automatic issue(input logic [1:0] v, input logic [31:0] d0, input logic [31:0] d1);
        int         n;
        logic [1:0] hs;
        n = 0;
        @(posedge clk);
        #1;
        req0_data = d0;
        req1_data = d1;
        req_valid = v;
        while ((req_valid != 2'b00) && (n < 300)) begin
            @(negedge clk);
            hs = req_valid & req_ready;
            @(posedge clk);
            #1;
            req_valid = req_valid & ~hs;
            if (hs[0]) req0_data = $urandom;
            if (hs[1]) req1_data = $urandom;
            n++;
        end
        if (req_valid != 2'b00) begin
            total++;
            bad++;
            $display("FAIL request_timeout actual=%0b required=00", req_valid);
            req_valid = 2'b00;
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (((sb.size() != 0) || res_valid) && (n < 600)) begin
            @(posedge clk);
            #2;
            n++;
        end
        if ((sb.size() != 0) || res_valid) begin
            total++;
            bad++;
            $display("FAIL drain_timeout actual=%0d required=0", sb.size());
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        resetn = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        resetn = 1'b1;
    endtask

    initial begin
        int n;
        resetn    = 1'b0;
        req_valid = 2'b00;
        req0_data = '0;
        req1_data = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_res_valid", 32'(res_valid), 32'd0);
        chk("rst_res_id", 32'(res_id), 32'd0);
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_job_count", 32'(job_count), 32'd0);
        chk("rst_dp_ctrl", 32'({dp_data_in, dp_ld_a, dp_ld_b, dp_ld_c, dp_ld_x, dp_ld_r,
                                dp_ld_alu_out, dp_alu_select_a, dp_alu_select_b, dp_alu_op}), 32'd0);
        resetn = 1'b1;

        // Both requesters right after reset: requester 0 first, then requester 1
        issue(2'b11, 32'h0702_0509, 32'h0101_0101);
        drain();
        // Lone requester 0: 2*25 + 3*5 + 4
        issue(2'b01, 32'h0203_0405, 32'h0);
        drain();
        @(posedge clk);
        #2;
        chk("job_count_3", 32'(job_count), 32'(exp_cnt(3)));
        // Lone requester 1: 3*100 wraps
        issue(2'b10, 32'h0, 32'h0300_000A);
        drain();

        // Held result under back-pressure; no new grants meanwhile
        bp_mode = 1;
        issue(2'b01, 32'h1122_3344, 32'h0);
        n = 0;
        while (!res_valid && (n < 40)) begin
            @(negedge clk);
            n++;
        end
        chk("stall_valid_rise", 32'(res_valid), 32'd1);
        @(posedge clk);
        #1;
        req0_data = 32'h0909_0909;
        req_valid = 2'b01;
        repeat (5) begin
            @(negedge clk);
            chk("stall_valid", 32'(res_valid), 32'd1);
            chk("stall_data", 32'(res_data), 32'(poly(32'h1122_3344)));
            chk("stall_ready", 32'(req_ready), 32'd0);
        end
        @(posedge clk);
        #1;
        req_valid = 2'b00;
        bp_mode   = 0;
        drain();

        // Reset while the job sits in C2, then a fresh requester-1 job
        issue(2'b01, 32'h0506_0708, 32'h0);
        repeat (6) @(posedge clk);
        #1;
        resetn = 1'b0;
        @(posedge clk);
        #1;
        resetn = 1'b1;
        chk("midrst_res_valid", 32'(res_valid), 32'd0);
        chk("midrst_dp_ld", 32'({dp_ld_a, dp_ld_b, dp_ld_c, dp_ld_x, dp_ld_r, dp_ld_alu_out}), 32'd0);
        chk("midrst_job_count", 32'(job_count), 32'd0);
        issue(2'b10, 32'h0, 32'h0A0B_0C0D);
        drain();

        // Randomized traffic with random back-pressure
        bp_mode = 2;
        for (int i = 0; i < 30; i++) begin
            issue(2'($urandom_range(1, 3)), $urandom, $urandom);
        end
        drain();
        bp_mode = 0;
        @(posedge clk);
        #2;
        chk("final_job_count", 32'(job_count), 32'(exp_cnt(hs_done)));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

endmodule
